// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Desc     : Shared FSM encoding and geometry helpers for the associative dcache
// Revision : 1.0
// ============================================================================
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MISS      = 3'd1,
        S_WRITEBACK = 3'd2,
        S_REFILL    = 3'd3,
        S_REFILL_OK = 3'd4
    } state_t;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
        return addr_w - $clog2(sets) - $clog2(line_bytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_way_store.sv
`default_nettype none
// ============================================================================
// Module   : dcache_way_store
// Desc     : One cache way: valid/dirty/tag/line arrays, async read, byte-merged write
// Revision : 1.0
// ============================================================================
module dcache_way_store
    import dcache_pkg::*;
#(
    parameter int SETS   = 32,
    parameter int TAG_W  = 22,
    parameter int LINE_W = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [idx_w(SETS)-1:0]    i_idx,
    output logic                      o_valid,
    output logic                      o_dirty,
    output logic [TAG_W-1:0]          o_tag,
    output logic [LINE_W-1:0]         o_line,
    input  logic                      i_we,
    input  logic [LINE_W/8-1:0]       i_be,
    input  logic [LINE_W-1:0]         i_wline,
    input  logic [TAG_W-1:0]          i_wtag,
    input  logic                      i_wdirty
);

    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_line [SETS];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_line[i_idx];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= i_wdirty;
        end
    end

    // Tag and line contents survive reset; only the valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_tag[i_idx] <= i_wtag;
            for (int b = 0; b < LINE_W/8; b++) begin
                if (i_be[b]) r_line[i_idx][b*8 +: 8] <= i_wline[b*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_assoc_top.sv
`default_nettype none
// ============================================================================
// Module   : dcache_assoc_top
// Desc     : 1/2-way write-back, write-allocate L1 data cache with LRU replacement
// Revision : 1.0
// ============================================================================
module dcache_assoc_top
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 32,
    parameter int WAYS       = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [LINE_BYTES*8-1:0]   mem_data_i,
    input  logic                      mem_ack_i,
    output logic [LINE_BYTES*8-1:0]   mem_data_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic                      mem_enable_o,
    output logic                      mem_write_o,
    input  logic [DATA_W-1:0]         p1_data_i,
    input  logic [DATA_W/8-1:0]       p1_be_i,
    input  logic [ADDR_W-1:0]         p1_addr_i,
    input  logic                      p1_MemRead_i,
    input  logic                      p1_MemWrite_i,
    output logic [DATA_W-1:0]         p1_data_o,
    output logic                      p1_stall_o
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_BYTES);
    localparam int BE_W   = DATA_W / 8;
    localparam int WORDS  = LINE_BYTES / BE_W;
    localparam int BOFF_W = $clog2(BE_W);

    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
        $error("dcache_assoc_top: WAYS must be 1 or 2");
    end

    state_t            r_state;
    logic              r_victim;
    logic              r_mem_en;
    logic              r_mem_wr;

    logic              w_req;
    logic [TAG_W-1:0]  w_req_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [OFF_W-1:0]  w_word_sel;
    logic [WAYS-1:0]   w_valid;
    logic [WAYS-1:0]   w_dirty;
    logic [WAYS-1:0]   w_hit_way;
    logic [WAYS-1:0]   w_we;
    logic [TAG_W-1:0]  w_tag  [WAYS];
    logic [LINE_W-1:0] w_line [WAYS];
    logic              w_hit;
    logic              w_hit_upd;
    logic              w_fill;
    logic              w_store;
    logic              w_victim_nxt;
    logic [LINE_W-1:0] w_hit_line;
    logic              w_vic_valid;
    logic              w_vic_dirty;
    logic [TAG_W-1:0]  w_vic_tag;
    logic [LINE_W-1:0] w_vic_line;
    logic [LINE_BYTES-1:0] w_st_be;
    logic [LINE_BYTES-1:0] w_wbe;
    logic [LINE_W-1:0] w_wline;
    logic              w_wdirty;

    assign w_req      = p1_MemRead_i | p1_MemWrite_i;
    assign w_req_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_idx      = p1_addr_i[OFF_W +: IDX_W];
    assign w_word_sel = p1_addr_i[OFF_W-1:0] >> BOFF_W;
    assign w_hit      = |w_hit_way;
    assign w_hit_upd  = (r_state == S_IDLE) & w_req & w_hit;
    assign w_fill     = (r_state == S_REFILL) & mem_ack_i;
    assign w_store    = (r_state == S_IDLE) & p1_MemWrite_i & w_hit;
    assign w_st_be    = LINE_BYTES'(p1_be_i) << (w_word_sel * BE_W);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_way_store #(
            .SETS   (SETS),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W)
        ) u_way (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .i_idx    (w_idx),
            .o_valid  (w_valid[w]),
            .o_dirty  (w_dirty[w]),
            .o_tag    (w_tag[w]),
            .o_line   (w_line[w]),
            .i_we     (w_we[w]),
            .i_be     (w_wbe),
            .i_wline  (w_wline),
            .i_wtag   (w_req_tag),
            .i_wdirty (w_wdirty)
        );
        assign w_hit_way[w] = w_valid[w] && (w_tag[w] == w_req_tag);
    end

    // The LRU bit names the way to evict next, so a hit points it at the other way.
    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] r_lru;
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i)         r_lru <= '0;
            else if (w_hit_upd) r_lru[w_idx] <= ~w_hit_way[1];
        end
        assign w_victim_nxt = !w_valid[0] ? 1'b0 :
                              !w_valid[1] ? 1'b1 : r_lru[w_idx];
    end else begin : g_no_lru
        assign w_victim_nxt = 1'b0;
    end

    always_comb begin
        w_hit_line  = '0;
        w_vic_valid = 1'b0;
        w_vic_dirty = 1'b0;
        w_vic_tag   = '0;
        w_vic_line  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit_way[w]) w_hit_line = w_line[w];
            if (int'(r_victim) == w) begin
                w_vic_valid = w_valid[w];
                w_vic_dirty = w_dirty[w];
                w_vic_tag   = w_tag[w];
                w_vic_line  = w_line[w];
            end
        end
    end

    always_comb begin
        w_we     = '0;
        w_wbe    = '0;
        w_wline  = {WORDS{p1_data_i}};
        w_wdirty = 1'b1;
        if (w_fill) begin
            w_we     = WAYS'(1) << r_victim;
            w_wbe    = '1;
            w_wline  = mem_data_i;
            w_wdirty = 1'b0;
        end else if (w_store) begin
            w_we  = w_hit_way;
            w_wbe = w_st_be;
        end
    end

    assign p1_data_o    = w_hit_line[w_word_sel*DATA_W +: DATA_W];
    assign p1_stall_o   = rst_i & w_req & (~w_hit | (r_state != S_IDLE));
    assign mem_enable_o = r_mem_en;
    assign mem_write_o  = r_mem_wr;
    assign mem_data_o   = w_vic_line;
    assign mem_addr_o   = (r_state == S_WRITEBACK) ? {w_vic_tag, w_idx, {OFF_W{1'b0}}}
                                                   : {w_req_tag, w_idx, {OFF_W{1'b0}}};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_victim <= 1'b0;
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_hit) begin
                        r_state  <= S_MISS;
                        r_victim <= w_victim_nxt;
                    end
                end
                S_MISS: begin
                    r_mem_en <= 1'b1;
                    if (w_vic_valid && w_vic_dirty) begin
                        r_state  <= S_WRITEBACK;
                        r_mem_wr <= 1'b1;
                    end else begin
                        r_state  <= S_REFILL;
                        r_mem_wr <= 1'b0;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_state  <= S_REFILL;
                        r_mem_wr <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        r_state  <= S_REFILL_OK;
                        r_mem_en <= 1'b0;
                    end
                end
                S_REFILL_OK: r_state <= S_IDLE;
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_en <= 1'b0;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_assoc_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dcache_assoc_top
// Desc     : Directed scoreboard bench for dcache_assoc_top (default geometry)
// Revision : 1.0
// ============================================================================
module tb_dcache_assoc_top;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [255:0]  mem_data_i = '0;
    logic          mem_ack_i = 1'b0;
    logic [255:0]  mem_data_o;
    logic [31:0]   mem_addr_o;
    logic          mem_enable_o;
    logic          mem_write_o;
    logic [31:0]   p1_data_i = '0;
    logic [3:0]    p1_be_i = '0;
    logic [31:0]   p1_addr_i = '0;
    logic          p1_MemRead_i = 1'b0;
    logic          p1_MemWrite_i = 1'b0;
    logic [31:0]   p1_data_o;
    logic          p1_stall_o;

    always #5 clk_i = ~clk_i;

    dcache_assoc_top #(
        .ADDR_W(32), .DATA_W(32), .LINE_BYTES(32), .SETS(32), .WAYS(2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_o   (mem_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .p1_data_i    (p1_data_i),
        .p1_be_i      (p1_be_i),
        .p1_addr_i    (p1_addr_i),
        .p1_MemRead_i (p1_MemRead_i),
        .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o)
    );

    typedef struct { bit wr; logic [31:0] addr; } txn_t;

    int          checks = 0;
    int          errors = 0;
    txn_t        exp_q[$];
    logic [31:0] ld_q[$];
    logic [31:0] bk  [int unsigned];   // backing memory words
    logic [31:0] cpu [int unsigned];   // CPU-visible words (includes dirty data)

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'h5A00_0000 ^ a ^ {a[15:0], 16'h0};
    endfunction

    function automatic logic [31:0] get_bk(input logic [31:0] a);
        return bk.exists(a) ? bk[a] : pat(a);
    endfunction

    function automatic logic [31:0] get_cpu(input logic [31:0] a);
        return cpu.exists(a) ? cpu[a] : get_bk(a);
    endfunction

    function automatic logic [255:0] bk_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = get_bk(la + 32'(k*4));
        return l;
    endfunction

    function automatic logic [255:0] cpu_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = get_cpu(la + 32'(k*4));
        return l;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // Drives one CPU access at a negedge and acts as the memory until the stall drops.
    task automatic access(input string tag, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input bit exp_wb, input logic [31:0] wb_addr,
                          input bit exp_fill, input int dly, input int exp_stall);
        int   stalls = 0;
        int   wait_cnt = 0;
        bit   in_txn = 0;
        bit   done = 0;
        txn_t t;
        txn_t cur;
        logic [31:0] exp_ld;
        if (exp_wb)   begin t.wr = 1'b1; t.addr = wb_addr;          exp_q.push_back(t); end
        if (exp_fill) begin t.wr = 1'b0; t.addr = {a[31:5], 5'b0}; exp_q.push_back(t); end
        if (!wr) ld_q.push_back(get_cpu(a));
        p1_addr_i = a; p1_data_i = d; p1_be_i = be;
        p1_MemRead_i = !wr; p1_MemWrite_i = wr;
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            if (!p1_stall_o) begin
                done = 1;
            end else begin
                stalls++;
                if (mem_enable_o && !in_txn) begin
                    in_txn = 1; wait_cnt = 0;
                    chk({tag, ":req_expected"}, 256'(exp_q.size() > 0), 256'd1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        chk({tag, ":mem_write"}, 256'(mem_write_o), 256'(cur.wr));
                        chk({tag, ":mem_addr"}, 256'(mem_addr_o), 256'(cur.addr));
                        if (cur.wr) begin
                            chk({tag, ":wb_data"}, mem_data_o, cpu_line(cur.addr));
                            for (int k = 0; k < 8; k++)
                                bk[cur.addr + 32'(k*4)] = mem_data_o[k*32 +: 32];
                        end
                    end
                end
                if (in_txn) begin
                    if (wait_cnt == dly) begin
                        mem_ack_i  = 1'b1;
                        mem_data_i = bk_line({a[31:5], 5'b0});
                        in_txn     = 0;
                    end
                    wait_cnt++;
                end
                @(negedge clk_i);
                mem_ack_i = 1'b0;
            end
        end
        chk({tag, ":completed"}, 256'(done), 256'd1);
        chk({tag, ":stall_cycles"}, 256'(stalls), 256'(exp_stall));
        chk({tag, ":mem_txns_left"}, 256'(exp_q.size()), 256'd0);
        exp_q.delete();
        if (!wr) begin
            exp_ld = ld_q.pop_front();
            if (done) chk({tag, ":load_data"}, 256'(p1_data_o), 256'(exp_ld));
        end else if (done) begin
            cpu[a] = merge(get_cpu(a), d, be);
        end
        @(negedge clk_i);
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        bit seen;
        bk[32'h44] = 32'hDEAD_BEEF;

        // Reset: outputs quiet even with a request pending.
        p1_MemRead_i = 1'b1; p1_addr_i = 32'h44;
        @(negedge clk_i); @(negedge clk_i); #1;
        chk("rst:mem_enable", 256'(mem_enable_o), 256'd0);
        chk("rst:mem_write",  256'(mem_write_o),  256'd0);
        chk("rst:stall",      256'(p1_stall_o),   256'd0);
        chk("rst:data",       256'(p1_data_o),    256'd0);
        p1_MemRead_i = 1'b0;
        @(negedge clk_i); rst_i = 1'b1;
        @(negedge clk_i);

        // Cold load, ack three cycles into the refill.
        access("t1_cold", 0, 32'h44, 0, 0, 0, 0, 1, 3, 7);
        // Partial store hit then reload.
        access("t2_store", 1, 32'h44, 32'h1122_3344, 4'b0011, 0, 0, 0, 0, 0);
        access("t2_load",  0, 32'h44, 0, 0, 0, 0, 0, 0, 0);
        chk("t2:literal", 256'(get_cpu(32'h44)), 256'(32'hDEAD_3344));

        // Spurious ack in IDLE must be ignored.
        mem_ack_i = 1'b1; mem_data_i = '1; #1;
        chk("t6:enable_during_ack", 256'(mem_enable_o), 256'd0);
        @(negedge clk_i); mem_ack_i = 1'b0; #1;
        chk("t6:enable_after_ack", 256'(mem_enable_o), 256'd0);
        chk("t6:write_after_ack",  256'(mem_write_o),  256'd0);
        @(negedge clk_i);
        access("t6_load", 0, 32'h44, 0, 0, 0, 0, 0, 0, 0);

        // Set-0 conflict: LRU picks way holding 0x400.
        access("t3_a",  0, 32'h000, 0, 0, 0, 0, 1, 1, 5);
        access("t3_b",  0, 32'h400, 0, 0, 0, 0, 1, 1, 5);
        access("t3_c",  0, 32'h000, 0, 0, 0, 0, 0, 0, 0);
        access("t3_d",  0, 32'h800, 0, 0, 0, 0, 1, 1, 5);
        access("t3_e",  0, 32'h000, 0, 0, 0, 0, 0, 0, 0);
        access("t3_f",  0, 32'h400, 0, 0, 0, 0, 1, 1, 5);

        // Store miss allocates; be=0 store still dirties a clean line.
        access("sm_st",  1, 32'h2028, 32'h9988_7766, 4'b1100, 0, 0, 1, 0, 4);
        access("sm_ld",  0, 32'h2028, 0, 0, 0, 0, 0, 0, 0);
        access("sm_b",   0, 32'h2420, 0, 0, 0, 0, 1, 0, 4);
        access("sm_be0", 1, 32'h2424, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, 0, 0);
        access("sm_ev1", 0, 32'h2820, 0, 0, 1, 32'h2020, 1, 0, 5);
        access("sm_ev2", 0, 32'h2020, 0, 0, 1, 32'h2420, 1, 0, 5);

        // Asynchronous reset during a refill.
        p1_addr_i = 32'h1060; p1_MemRead_i = 1'b1; seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i); #1;
            if (mem_enable_o) seen = 1;
        end
        chk("t5:refill_started", 256'(seen), 256'd1);
        rst_i = 1'b0; #1;
        chk("t5:enable_async_drop", 256'(mem_enable_o), 256'd0);
        chk("t5:stall_in_reset",    256'(p1_stall_o),   256'd0);
        cpu.delete();
        @(negedge clk_i); rst_i = 1'b1; p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        access("t5_reload", 0, 32'h1060, 0, 0, 0, 0, 1, 0, 4);
        access("t5_44",     0, 32'h44,   0, 0, 0, 0, 1, 0, 4);

        // Dirty eviction of 0x000 by 0x800.
        access("t4_a",  0, 32'h000, 0, 0, 0, 0, 1, 0, 4);
        access("t4_b",  0, 32'h400, 0, 0, 0, 0, 1, 0, 4);
        access("t4_st", 1, 32'h000, 32'hCAFE_F00D, 4'b1111, 0, 0, 0, 0, 0);
        access("t4_c",  0, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        access("t4_d",  0, 32'h800, 0, 0, 1, 32'h000, 1, 1, 7);
        access("t4_e",  0, 32'h000, 0, 0, 0, 0, 1, 0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_assoc_top.md
Name: dcache_assoc_top

Overview:
Parametrised write-back, write-allocate L1 data cache between the CPU data port (p1_*) and line-wide data memory (mem_*).
- Generalises the direct-mapped dcache to 1- or 2-way set associativity, with LRU replacement.
- Adds configurable line and set geometry and byte-enable stores.
- Keeps the same stall-based CPU handshake and enable/ack memory handshake.

Parameters:
ADDR_W, 32, CPU/memory byte-address width
DATA_W, 32, CPU word width (multiple of 8)
LINE_BYTES, 32, line size in bytes (power of 2, ≥ DATA_W/8); LINE_W = LINE_BYTES*8
SETS, 32, number of sets (power of 2); IDX_W = log2(SETS), OFF_W = log2(LINE_BYTES), TAG_W = ADDR_W-IDX_W-OFF_W
WAYS, 2, associativity (1 or 2 only; other values rejected at elaboration)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
mem_data_i  in  LINE_W  refill line from memory
mem_ack_i  in  1  memory completion, one-cycle pulse
mem_data_o  out  LINE_W  write-back line
mem_addr_o  out  ADDR_W  line-aligned address (offset bits = 0)
mem_enable_o  out  1  memory request valid
mem_write_o  out  1  1 = write-back, 0 = refill read
p1_data_i  in  DATA_W  store data
p1_be_i  in  DATA_W/8  store byte enables
p1_addr_i  in  ADDR_W  byte address; word-aligned
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request
p1_data_o  out  DATA_W  load data
p1_stall_o  out  1  CPU must hold request

Behaviour:
- Address split:
  - offset = addr[OFF_W-1:0]
  - index = addr[OFF_W+IDX_W-1:OFF_W]
  - tag = upper TAG_W bits
  - word select = offset[OFF_W-1:log2(DATA_W/8)]
- Storage, per set and way: valid, dirty, tag and line. Per set: one LRU bit (WAYS=2; it names the way to evict next). Reads are combinational; writes take effect on the clock edge.
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE; all valid, dirty and LRU bits = 0.
  - mem_enable_o=0, mem_write_o=0.
  - Line data is not cleared.
- Request: req = p1_MemRead_i | p1_MemWrite_i. If both are asserted, the access is treated as a write.
- Hit: in some way w, valid[w] && tag[w]==tag. At most one way may match.
- p1_stall_o = req & (~hit | state!=IDLE). Combinational; reset value 0.
- p1_data_o: selected word of the hit line. Don't-care when not a hit; it is 0 under reset.
- Load hit: zero extra latency, no stall. LRU is set to the other way.
- Store hit: same cycle, no stall.
  - Bytes with p1_be_i=1 are merged into the line; other bytes are unchanged.
  - dirty[w]=1; LRU set to the other way.
  - p1_be_i=0 still sets dirty.
- Victim selection, on entry to MISS, latched for the whole miss: lowest-numbered invalid way, else the LRU way.
- FSM:
  - IDLE: req & ~hit -> MISS. Otherwise stay in IDLE; mem_enable_o=0.
  - MISS (1 cycle, latches victim): victim valid & dirty -> WRITEBACK; else -> REFILL.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 0}, mem_data_o=victim line. Hold until mem_ack_i, then -> REFILL.
  - REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={tag, index, 0}. Hold until mem_ack_i. On the ack edge: write mem_data_i into the victim way, valid=1, dirty=0, tag=request tag. Then -> REFILL_OK.
  - REFILL_OK: 1 cycle, -> IDLE. The access then completes as a hit, and a store then merges and sets dirty.
- Miss latency = 3 + write-back ack wait (if dirty) + refill ack wait. Minimum: a clean miss with a 1-cycle ack costs 4 stall cycles.
- mem_enable_o and mem_write_o are registered.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- Request inputs must be held stable while stalled; behaviour otherwise is undefined.
- WAYS=1: LRU logic is absent and the victim is always way 0.

Decomposition:
- Package dcache_pkg: state encoding (IDLE, MISS, WRITEBACK, REFILL, REFILL_OK as a 3-bit enum) and the derived-width helper functions (clog2-based OFF_W, IDX_W, TAG_W).
- Sub-module dcache_way_store: one instance per way, parametrised by SETS, TAG_W, LINE_W. Holds valid, dirty, tag and line arrays, with async read and a synchronous write port (full-line or byte-merged).
- LRU bits and FSM live in the top module.

Test Plan (defaults: offset 5 bits, index 5 bits, tag 22 bits):
1. Cold load of 0x0000_0044:
   - Stall is asserted; after MISS, mem_enable_o=1, mem_write_o=0, mem_addr_o=0x0000_0040.
   - Ack after 3 cycles with a line whose word1 = 0xDEAD_BEEF.
   - After REFILL_OK, p1_data_o=0xDEAD_BEEF and stall drops.
2. Store 0x1122_3344 with be=4'b0011 to 0x44 (now a hit):
   - No stall; a following load of 0x44 returns 0xDEAD_3344.
3. Conflict in set 0: load 0x000, then 0x400, then load 0x000 again (hit; way1 becomes LRU), then load 0x800:
   - Refill goes to way1 (evicts 0x400); load 0x000 still hits with no mem activity.
4. Dirty eviction: store to 0x000, load 0x400 (hit), load 0x800:
   - WRITEBACK with mem_addr_o=0x000, mem_write_o=1, and mem_data_o carrying the stored word.
   - After the ack, a refill read of 0x800 follows.
5. Reset mid-REFILL (rst_i low 1 cycle, async):
   - mem_enable_o drops immediately and the state is IDLE.
   - A reload of the same address misses again (valid was cleared).
6. Spurious mem_ack_i pulse in IDLE:
   - No state change, no storage write, mem_enable_o stays 0.
